// File: rtl/dmem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_bridge
// Brief    : Turns single-cycle CPU data-memory accesses into req/ack bus
//            transactions and stalls the CPU while each one is in flight.
//            Optional bus_ack timeout: define DMEM_BRIDGE_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module dmem_bus_bridge #(
    parameter logic [31:0] DMEM_BASE   = 32'h1001_0000,
    parameter int          AW          = 11,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dmem_ena,
    input  logic          dmem_W,
    input  logic          dmem_R,
    input  logic [31:0]   dmem_addr,
    input  logic [31:0]   dmem_data_w,
    output logic [31:0]   dmem_data_r,
    output logic          cpu_stall,
    output logic          dmem_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ack,
    input  logic [31:0]   bus_rdata
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_REQ  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] w_off;
    logic        w_valid;
    logic        w_timeout;

    // Loads and stores share one path: a store wins when both strobes are set,
    // so the read strobe carries no extra information.
    logic w_unused_rd;
    assign w_unused_rd = dmem_R;

    assign w_off   = dmem_addr - DMEM_BASE;
    assign w_valid = (w_off[1:0] == 2'b00) && (w_off[31:AW+2] == '0);

    // Gated by rst so every output reads 0 while reset is held.
    assign cpu_stall   = rst & (((r_state == C_ST_IDLE) & dmem_ena) | (r_state == C_ST_REQ));
    assign dmem_data_r = r_rdata;
    assign dmem_err    = r_err;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int C_CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYC - 1);

    logic [C_CNT_W-1:0] r_cnt;

    // Counts un-acked REQ cycles; the edge that would reach the limit times out.
    assign w_timeout = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state != C_ST_REQ) begin
            r_cnt <= '0;
        end else if (!bus_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    localparam int c_unused_timeout_cyc = TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= C_ST_IDLE;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (dmem_ena) begin
                        if (w_valid) begin
                            bus_req   <= 1'b1;
                            bus_we    <= dmem_W;
                            bus_addr  <= w_off[AW+1:2];
                            bus_wdata <= dmem_data_w;
                            r_state   <= C_ST_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= C_ST_DONE;
                        end
                    end
                end
                C_ST_REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            r_rdata <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        r_state <= C_ST_DONE;
                    end else if (w_timeout) begin
                        bus_req <= 1'b0;
                        r_rdata <= 32'hDEAD_BEEF;
                        r_err   <= 1'b1;
                        r_state <= C_ST_DONE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_bridge.sv
`default_nettype none
// Testbench for dmem_bus_bridge: directed table, reset sequences, randomized
// instructions against a transaction-level model, and the ack-never-comes case.
module tb_dmem_bus_bridge;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          AW   = 11;
    localparam int          TO   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dmem_ena = 1'b0, dmem_W = 1'b0, dmem_R = 1'b0;
    logic [31:0]   dmem_addr = '0, dmem_data_w = '0;
    logic [31:0]   dmem_data_r;
    logic          cpu_stall, dmem_err, bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_ack = 1'b0;
    logic [31:0]   bus_rdata = '0;

    dmem_bus_bridge #(.DMEM_BASE(BASE), .AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .dmem_ena(dmem_ena), .dmem_W(dmem_W), .dmem_R(dmem_R),
        .dmem_addr(dmem_addr), .dmem_data_w(dmem_data_w), .dmem_data_r(dmem_data_r),
        .cpu_stall(cpu_stall), .dmem_err(dmem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            ena, w, r;
        logic [31:0]   addr, wdata;
        int            wait_c;
        logic [31:0]   rd;
        logic [AW-1:0] e_addr;
        bit            e_we;
        int            e_stall;
        logic [31:0]   e_data;
        bit            e_err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model state: what the CPU should see after each instruction.
    logic [31:0] m_rdata;
    bit          m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off % 4 == 0) && (off < (32'd4 << AW));
    endfunction

    task automatic gen_rand(output vec_t v);
        int kind;
        v.ena    = ($urandom_range(0, 3) != 0);
        v.w      = $urandom_range(0, 1);
        v.r      = v.w ? bit'($urandom_range(0, 1)) : 1'b1;
        v.wdata  = $urandom;
        v.wait_c = $urandom_range(0, 3);
        v.rd     = $urandom;
        kind     = $urandom_range(0, 4);
        case (kind)
            0, 1, 2: v.addr = BASE + 4 * $urandom_range(0, (1 << AW) - 1);
            3:       v.addr = BASE + 4 * $urandom_range(0, 500) + $urandom_range(1, 3);
            default: v.addr = $urandom_range(0, 1) ? BASE + (32'd4 << AW) + 4 * $urandom_range(0, 999)
                                                   : BASE - 4 * $urandom_range(1, 100);
        endcase
        v.e_addr = AW'((v.addr - BASE) / 4);
        v.e_we   = v.w;
        if (!v.ena) begin
            v.e_stall = 0;
        end else if (!addr_ok(v.addr)) begin
            v.e_stall = 1;
            m_err     = 1'b1;
            m_rdata   = '0;
        end else begin
            v.e_stall = v.wait_c + 2;
            if (!v.w) m_rdata = v.rd;
        end
        v.e_data = m_rdata;
        v.e_err  = m_err;
    endtask

    // One CPU instruction: inputs held while stalled, bus answered after wait_c cycles.
    task automatic run_instr(input vec_t v, input string nm);
        int stall_n = 0;
        int req_n   = 0;
        bit done    = 1'b0;
        for (int k = 0; k < v.wait_c + 20 && !done; k++) begin
            @(negedge clk);
            dmem_ena = v.ena; dmem_W = v.w; dmem_R = v.r;
            dmem_addr = v.addr; dmem_data_w = v.wdata;
            bus_ack = 1'b0; bus_rdata = $urandom;
            #1;
            if (bus_req) begin
                if (req_n == 0) begin
                    chk($sformatf("%s.bus_addr", nm), 32'(bus_addr), 32'(v.e_addr));
                    chk($sformatf("%s.bus_we", nm), 32'(bus_we), 32'(v.e_we));
                    if (v.e_we) chk($sformatf("%s.bus_wdata", nm), bus_wdata, v.wdata);
                end
                req_n++;
                if (req_n == v.wait_c + 1) begin
                    bus_ack = 1'b1; bus_rdata = v.rd;
                end
            end else begin
                bus_ack = 1'($urandom_range(0, 1));   // stray ack outside a transaction
            end
            if (!cpu_stall) done = 1'b1;
            else            stall_n++;
        end
        chk($sformatf("%s.completed", nm), 32'(done), 32'd1);
        chk($sformatf("%s.stall_cycles", nm), 32'(stall_n), 32'(v.e_stall));
        chk($sformatf("%s.req_cycles", nm), 32'(req_n), 32'((v.e_stall > 1) ? v.e_stall - 1 : 0));
        chk($sformatf("%s.data_r", nm), dmem_data_r, v.e_data);
        chk($sformatf("%s.err", nm), 32'(dmem_err), 32'(v.e_err));
    endtask

    task automatic chk_all_zero(input string nm);
        chk($sformatf("%s.bus_req", nm), 32'(bus_req), 0);
        chk($sformatf("%s.bus_we", nm), 32'(bus_we), 0);
        chk($sformatf("%s.bus_addr", nm), 32'(bus_addr), 0);
        chk($sformatf("%s.bus_wdata", nm), bus_wdata, 0);
        chk($sformatf("%s.cpu_stall", nm), 32'(cpu_stall), 0);
        chk($sformatf("%s.err", nm), 32'(dmem_err), 0);
        chk($sformatf("%s.data_r", nm), dmem_data_r, 0);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   cnt_s, cnt_r;
        bit   seen;

        tbl[0] = '{1, 0, 1, 32'h1001_0008, 32'h0,         2, 32'hCAFE_F00D, 11'h002, 0, 4, 32'hCAFE_F00D, 0};
        tbl[1] = '{1, 1, 0, 32'h1001_0010, 32'h1234_5678, 0, 32'hFFFF_FFFF, 11'h004, 1, 2, 32'hCAFE_F00D, 0};
        tbl[2] = '{0, 0, 0, 32'h1001_0008, 32'h0,         0, 32'h0,         11'h000, 0, 0, 32'hCAFE_F00D, 0};
        tbl[3] = '{1, 0, 1, 32'h1001_1FFC, 32'h0,         1, 32'hA5A5_A5A5, 11'h7FF, 0, 3, 32'hA5A5_A5A5, 0};
        tbl[4] = '{1, 1, 1, 32'h1001_0000, 32'h0BAD_F00D, 0, 32'h7777_7777, 11'h000, 1, 2, 32'hA5A5_A5A5, 0};
        tbl[5] = '{1, 0, 1, 32'h1001_0002, 32'h0,         0, 32'h0,         11'h000, 0, 1, 32'h0,         1};
        tbl[6] = '{1, 0, 1, 32'h1001_0004, 32'h0,         0, 32'h1122_3344, 11'h001, 0, 2, 32'h1122_3344, 1};
        tbl[7] = '{1, 0, 1, 32'h1001_0008, 32'h0,         3, 32'h55AA_55AA, 11'h002, 0, 5, 32'h55AA_55AA, 1};
        tbl[8] = '{1, 0, 1, 32'h1001_2000, 32'h0,         0, 32'h0,         11'h000, 0, 1, 32'h0,         1};
        tbl[9] = '{1, 1, 0, 32'h1000_FFFC, 32'h0,         0, 32'h0,         11'h000, 1, 1, 32'h0,         1};

        // Reset held with random inputs: everything reads 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_ena = 1'($urandom); dmem_W = 1'($urandom); dmem_R = 1'($urandom);
            dmem_addr = BASE + 4 * $urandom_range(0, 15); dmem_data_w = $urandom;
            bus_ack = 1'($urandom); bus_rdata = $urandom;
            #1;
            chk_all_zero($sformatf("reset%0d", i));
        end
        @(negedge clk);
        dmem_ena = 1'b0; bus_ack = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a pending request.
        @(negedge clk);
        dmem_ena = 1'b1; dmem_W = 1'b0; dmem_R = 1'b1; dmem_addr = 32'h1001_0020; bus_ack = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = bus_req;
        end
        chk("midreq.req_seen", 32'(seen), 1);
        rst = 1'b0;
        #1;
        chk("midreq.bus_req", 32'(bus_req), 0);
        chk("midreq.cpu_stall", 32'(cpu_stall), 0);
        chk("midreq.err", 32'(dmem_err), 0);
        chk("midreq.data_r", dmem_data_r, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreq.idle_stall", 32'(cpu_stall), 1);
        chk("midreq.idle_req", 32'(bus_req), 0);
        dmem_ena = 1'b0;

        m_rdata = '0;
        m_err   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            gen_rand(v);
            run_instr(v, $sformatf("rnd%0d", i));
        end

        // A load whose ack never arrives.
        @(negedge clk);
        dmem_ena = 1'b1; dmem_W = 1'b0; dmem_R = 1'b1; dmem_addr = 32'h1001_0040; bus_ack = 1'b0;
        cnt_s = 0; cnt_r = 0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        seen = 1'b0;
        for (int k = 0; k < TO + 20 && !seen; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus_req) cnt_r++;
            if (!cpu_stall) seen = 1'b1;
        end
        chk("timeout.completed", 32'(seen), 1);
        chk("timeout.req_cycles", 32'(cnt_r), 32'(TO));
        chk("timeout.data_r", dmem_data_r, 32'hDEAD_BEEF);
        chk("timeout.err", 32'(dmem_err), 1);
`else
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (cpu_stall) cnt_s++;
            if (bus_req)   cnt_r++;
        end
        chk("noack.stall_cycles", 32'(cnt_s), 1000);
        chk("noack.req_cycles", 32'(cnt_r), 999);
`endif
        dmem_ena = 1'b0;
        rst = 1'b0;
        #1;
        chk("final_reset.bus_req", 32'(bus_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
